// File: rtl/ps2_keycode_decoder_if.sv
// PS/2 keycode decoder signal bundle: raw keyboard lines in, decoded bytes out.
// master = keyboard/host side driving the PS/2 lines, slave = the decoder.
interface ps2_keycode_decoder_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       frame_err;

  modport master (
    output PS2_CLK,
    output PS2_DAT,
    input  keycode,
    input  rx_byte,
    input  rx_strobe,
    input  frame_err
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DAT,
    output keycode,
    output rx_byte,
    output rx_strobe,
    output frame_err
  );
endinterface

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, deserializes
// 11-bit frames (start, D0..D7, odd parity, stop), and tracks the scan code
// of the currently held non-extended key through a small make/break FSM.
module ps2_keycode_decoder #(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input logic             CLOCK_50,
  input logic             resetn,
  ps2_keycode_decoder_if.slave ps2
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  // synchronizer and edge-detect flops
  logic clk_sync1_reg, clk_sync2_reg, clk_prev_reg;
  logic dat_sync1_reg, dat_sync2_reg;

  // frame deserializer
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] timeout_reg;

  // outputs and byte FSM
  logic [7:0] rx_byte_reg;
  logic       rx_strobe_reg;
  logic       frame_err_reg;
  logic [7:0] keycode_reg, keycode_next;
  state_t     state_reg, state_next;

  logic ps2_fall;
  logic frame_end;
  logic frame_good;

  assign ps2_fall   = clk_prev_reg & ~clk_sync2_reg;
  assign frame_end  = ps2_fall && (bit_cnt_reg == 4'd10);
  // odd parity over D0..D7 plus parity bit, and stop bit (current sample) must be 1
  assign frame_good = frame_end && (^{parity_reg, shift_reg}) && dat_sync2_reg;

  // Two-flop synchronizers on both PS/2 lines, plus one extra clock stage for edge detection
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      clk_sync1_reg <= 1'b0;
      clk_sync2_reg <= 1'b0;
      clk_prev_reg  <= 1'b0;
      dat_sync1_reg <= 1'b0;
      dat_sync2_reg <= 1'b0;
    end else begin
      clk_sync1_reg <= ps2.PS2_CLK;
      clk_sync2_reg <= clk_sync1_reg;
      clk_prev_reg  <= clk_sync2_reg;
      dat_sync1_reg <= ps2.PS2_DAT;
      dat_sync2_reg <= dat_sync1_reg;
    end
  end

  // Inactivity counter: cleared by every PS/2 falling edge, saturates at the limit
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      timeout_reg <= '0;
    end else if (ps2_fall) begin
      timeout_reg <= '0;
    end else if (timeout_reg != TIMEOUT_MAX) begin
      timeout_reg <= timeout_reg + 1'b1;
    end
  end

  // Bit position tracking and data capture; a stalled partial frame is dropped silently
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'h00;
      parity_reg  <= 1'b0;
    end else if (ps2_fall) begin
      if (bit_cnt_reg == 4'd0) begin
        // a start bit sampled high is noise: stay waiting for a real start
        bit_cnt_reg <= dat_sync2_reg ? 4'd0 : 4'd1;
      end else if (bit_cnt_reg == 4'd10) begin
        bit_cnt_reg <= 4'd0;
      end else begin
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
        if (bit_cnt_reg <= 4'd8) begin
          shift_reg <= {dat_sync2_reg, shift_reg[7:1]};
        end else begin
          parity_reg <= dat_sync2_reg;
        end
      end
    end else if (timeout_reg == TIMEOUT_MAX && bit_cnt_reg != 4'd0) begin
      bit_cnt_reg <= 4'd0;
    end
  end

  // Byte-level results: strobe and new byte on a good frame, error pulse on a bad one
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      rx_byte_reg   <= 8'h00;
      rx_strobe_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_strobe_reg <= frame_good;
      frame_err_reg <= frame_end && !frame_good;
      if (frame_good) begin
        rx_byte_reg <= shift_reg;
      end
    end
  end

  // Make/break FSM state and held keycode register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= S_IDLE;
      keycode_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      keycode_reg <= keycode_next;
    end
  end

  // Next-state and keycode update, advancing only on a good received byte
  always_comb begin
    state_next   = state_reg;
    keycode_next = keycode_reg;
    if (frame_good) begin
      unique case (state_reg)
        S_IDLE: begin
          if (shift_reg == 8'hF0) begin
            state_next = S_BRK;
          end else if (shift_reg == 8'hE0) begin
            state_next = S_EXT;
          end else begin
            keycode_next = shift_reg;
          end
        end
        S_BRK: begin
          // releasing a key other than the held one leaves keycode alone
          if (shift_reg == keycode_reg) begin
            keycode_next = 8'h00;
          end
          state_next = S_IDLE;
        end
        S_EXT: begin
          state_next = (shift_reg == 8'hF0) ? S_EXT_BRK : S_IDLE;
        end
        S_EXT_BRK: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  assign ps2.keycode   = keycode_reg;
  assign ps2.rx_byte   = rx_byte_reg;
  assign ps2.rx_strobe = rx_strobe_reg;
  assign ps2.frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Testbench for ps2_keycode_decoder: directed key sequences with literal
// expectations, then randomized frames, errors, stalls and resets compared
// every cycle against a frame-level behavioural model.
module tb_ps2_keycode_decoder;

  localparam int TO   = 200;  // scaled-down inactivity limit
  localparam int HALF = 16;   // PS/2 half period in CLOCK_50 cycles

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_keycode_decoder_if bus();

  ps2_keycode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .ps2      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_err = 0;

  // expected frame outcomes, {good, byte}, pushed when the 11th edge is driven
  bit [8:0]   exp_q[$];
  logic [7:0] m_key = 8'h00;
  logic [7:0] m_rxb = 8'h00;
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;
  int         wait_cnt = 0;

  logic [7:0] pool [6] = '{8'h1C, 8'h1D, 8'h29, 8'h23, 8'h12, 8'h00};

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %02h, expected %02h", name, $time, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model of the key tracker, stated as "what does this byte mean given the prefix"
  task automatic model_byte(input logic [7:0] b);
    if (m_ext) begin
      if (b == 8'hF0 && !m_brk) m_brk = 1'b1;
      else begin m_ext = 1'b0; m_brk = 1'b0; end
    end else if (m_brk) begin
      if (b == m_key) m_key = 8'h00;
      m_brk = 1'b0;
    end else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else m_key = b;
  endtask

  // Per-cycle comparison of the DUT against the model
  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      m_key = 8'h00; m_rxb = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
      exp_q.delete();
      wait_cnt = 0;
      chki("reset_pulses", int'({bus.rx_strobe, bus.frame_err}), 0);
      chk8("reset_keycode", bus.keycode, 8'h00);
      chk8("reset_rx_byte", bus.rx_byte, 8'h00);
    end else begin
      if (bus.rx_strobe) n_strobe++;
      if (bus.frame_err) n_err++;
      if (bus.rx_strobe && bus.frame_err) chki("strobe_and_err", 1, 0);
      if (bus.rx_strobe || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          chki("unexpected_pulse", int'({bus.rx_strobe, bus.frame_err}), 0);
        end else begin
          bit [8:0] e;
          e = exp_q.pop_front();
          wait_cnt = 0;
          chki("pulse_kind", int'({bus.rx_strobe, bus.frame_err}), e[8] ? 2 : 1);
          if (e[8]) begin
            m_rxb = e[7:0];
            model_byte(e[7:0]);
          end
        end
      end else if (exp_q.size() > 0) begin
        wait_cnt++;
        if (wait_cnt > 12) begin
          chki("pulse_timeout", wait_cnt, 0);
          void'(exp_q.pop_front());
          wait_cnt = 0;
        end
      end
      chk8("keycode", bus.keycode, m_key);
      chk8("rx_byte", bus.rx_byte, m_rxb);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Drive the first nbits of a frame; a full frame registers its outcome with the model
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    bit [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (~^b) ^ bad_par;
    f[10]  = ~bad_stop;
    for (int i = 0; i < nbits; i++) begin
      bus.PS2_DAT = f[i];
      wait_clk(HALF);
      bus.PS2_CLK = 1'b0;
      if (i == 10) exp_q.push_back({!(bad_par || bad_stop), b});
      wait_clk(HALF);
      bus.PS2_CLK = 1'b1;
    end
    wait_clk(HALF);
    bus.PS2_DAT = 1'b1;
    $display("frame %02h bits=%0d bad_par=%0d bad_stop=%0d -> keycode %02h", b, nbits,
             bad_par, bad_stop, bus.keycode);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic reset_pulse();
    @(negedge CLOCK_50);
    #2 resetn = 1'b0;
    #1;
    chk8("async_rst_keycode", bus.keycode, 8'h00);
    chk8("async_rst_rx_byte", bus.rx_byte, 8'h00);
    chki("async_rst_pulses", int'({bus.rx_strobe, bus.frame_err}), 0);
    wait_clk(3);
    resetn = 1'b1;
    wait_clk(4);
    $display("reset pulse -> keycode %02h", bus.keycode);
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 20) return 8'hF0;
    if (r < 32) return 8'hE0;
    if (r < 75) return pool[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int s0, e0;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    #5 resetn = 1'b0;
    wait_clk(4);
    resetn = 1'b1;
    wait_clk(4);

    // 1D make, then its break
    s0 = n_strobe;
    key(8'h1D);
    chk8("make_1D_key", bus.keycode, 8'h1D);
    chk8("make_1D_rx", bus.rx_byte, 8'h1D);
    key(8'hF0);
    chk8("brk_prefix_key", bus.keycode, 8'h1D);
    key(8'h1D);
    chk8("brk_1D_key", bus.keycode, 8'h00);
    chki("strobes_3", n_strobe - s0, 3);

    // last key wins; break of a non-held key is ignored
    key(8'h1D);
    key(8'h1C);
    chk8("last_wins", bus.keycode, 8'h1C);
    key(8'hF0);
    key(8'h1D);
    chk8("brk_not_held", bus.keycode, 8'h1C);
    key(8'h1C);
    chk8("typematic", bus.keycode, 8'h1C);
    key(8'hF0);
    key(8'h1C);
    chk8("brk_1C", bus.keycode, 8'h00);

    // bad parity frame is dropped
    key(8'h1C);
    s0 = n_strobe; e0 = n_err;
    send_frame(8'h29, 1'b1, 1'b0, 11);
    chki("bad_par_err", n_err - e0, 1);
    chki("bad_par_nostrobe", n_strobe - s0, 0);
    chk8("bad_par_key", bus.keycode, 8'h1C);
    chk8("bad_par_rx", bus.rx_byte, 8'h1C);
    key(8'h29);
    chk8("after_bad_key", bus.keycode, 8'h29);
    key(8'hF0);
    key(8'h29);

    // extended make and break never touch keycode
    s0 = n_strobe;
    key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
    chki("ext_strobes", n_strobe - s0, 5);
    chk8("ext_key", bus.keycode, 8'h00);
    key(8'h1C);
    chk8("ext_back_idle", bus.keycode, 8'h1C);

    // stalled partial frame is discarded without error
    e0 = n_err;
    send_frame(8'h5A, 1'b0, 1'b0, 6);
    wait_clk(TO + 60);
    key(8'h23);
    chk8("timeout_key", bus.keycode, 8'h23);
    chki("timeout_noerr", n_err - e0, 0);

    // reset in the middle of a frame
    key(8'h12);
    chk8("pre_reset_key", bus.keycode, 8'h12);
    send_frame(8'h44, 1'b0, 1'b0, 5);
    reset_pulse();
    key(8'h1B);
    chk8("post_reset_key", bus.keycode, 8'h1B);

    // randomized traffic against the model
    for (int it = 0; it < 100; it++) begin
      int r;
      bit bp, bs;
      r = $urandom_range(0, 99);
      if (r < 6) begin
        bus.PS2_DAT = 1'b1;
        wait_clk(HALF);
        bus.PS2_CLK = 1'b0;
        wait_clk(HALF);
        bus.PS2_CLK = 1'b1;
        wait_clk(HALF);
        $display("spurious edge with data high -> keycode %02h", bus.keycode);
      end else if (r < 13) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, $urandom_range(1, 10));
        wait_clk(TO + 60);
      end else if (r < 17) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, $urandom_range(1, 10));
        reset_pulse();
      end else if (r < 27) begin
        bp = 1'($urandom_range(0, 1));
        bs = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        send_frame(pick_byte(), bp, bs, 11);
      end else begin
        key(pick_byte());
      end
      wait_clk($urandom_range(2, 20));
    end

    wait_clk(20);
    chki("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
